// File: rtl/icap_word_serializer_pkg.sv
// rtl/icap_word_serializer_pkg.sv - shared state encoding and ICAP constants for the word serializer
package icap_pkg;

   localparam int ICAP_WORD_W = 32;

   localparam logic CSIB_ENABLE  = 1'b0;
   localparam logic CSIB_DISABLE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

endpackage

// File: rtl/icap_word_serializer_if.sv
// rtl/icap_word_serializer_if.sv - FIFO-side and ICAP-side signal bundle of the word serializer
interface icap_word_serializer_if
   import icap_pkg::*;
#(
   parameter int DATA_SIZE = 256
);

   logic                   enable;
   logic                   abort;
   logic                   fifo_empty;
   logic                   fifo_rd_en;
   logic [DATA_SIZE-1:0]   fifo_data;
   logic [ICAP_WORD_W-1:0] icap_data;
   logic                   icap_csib;
   logic                   icap_rdwrb;
   logic                   busy;
   logic [31:0]            words_sent;

   // master is the serializer itself, slave is the surrounding FIFO/ICAP environment
   modport master (
      input  enable, abort, fifo_empty, fifo_data,
      output fifo_rd_en, icap_data, icap_csib, icap_rdwrb, busy, words_sent
   );

   modport slave (
      output enable, abort, fifo_empty, fifo_data,
      input  fifo_rd_en, icap_data, icap_csib, icap_rdwrb, busy, words_sent
   );

endinterface

// File: rtl/icap_word_serializer_bitswap.sv
// rtl/icap_word_serializer_bitswap.sv - byte-wise bit reversal of one 32-bit ICAP word
module icap_bitswap
   import icap_pkg::*;
(
   input  logic [ICAP_WORD_W-1:0] word,
   output logic [ICAP_WORD_W-1:0] swapped
);

   for (genvar b = 0; b < ICAP_WORD_W / 8; b++) begin : g_byte
      for (genvar k = 0; k < 8; k++) begin : g_bit
         assign swapped[8*b + k] = word[8*b + 7 - k];
      end
   end

endmodule

// File: rtl/icap_word_serializer.sv
// rtl/icap_word_serializer.sv - splits wide FIFO words into 32-bit ICAP writes; ICAP_BITSWAP_EN reverses bits per byte
module icap_word_serializer
   import icap_pkg::*;
#(
   parameter int DATA_SIZE = 256
) (
   input  logic                  clock,
   input  logic                  reset,
   icap_word_serializer_if.master bus
);

   localparam int WORD_COUNT = DATA_SIZE / ICAP_WORD_W;
   localparam int IDX_W      = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

   state_t                 state;
   state_t                 state_next;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       idx_next;
   logic                   rd_en;
   logic                   last_word;
   logic [DATA_SIZE-1:0]   holding;
   logic [DATA_SIZE-1:0]   source;
   logic [ICAP_WORD_W-1:0] word_sel;
   logic [ICAP_WORD_W-1:0] word_out;
   logic [ICAP_WORD_W-1:0] data_q;
   logic                   csib_q;
   logic [31:0]            words_sent_q;

   assign last_word = (idx == LAST_IDX);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      rd_en      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.enable && !bus.fifo_empty) begin
               state_next = READ;
            end
         end
         READ: begin
            rd_en      = 1'b1;
            state_next = LOAD;
         end
         LOAD: begin
            idx_next   = '0;
            state_next = SEND;
         end
         SEND: begin
            if (!last_word) begin
               idx_next = idx + IDX_W'(1);
            end else if (bus.enable && !bus.fifo_empty) begin
               // back-to-back refill: the read overlaps the last word, costing one csib bubble
               rd_en      = 1'b1;
               state_next = LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (bus.abort) begin
         state_next = IDLE;
         idx_next   = '0;
         rd_en      = 1'b0;
      end
   end

   // Output registers are loaded from the upcoming word so csib is low exactly while state is SEND;
   // when entering from LOAD the word comes straight from the FIFO because holding is loading on the same edge.
   assign source   = (state == LOAD) ? bus.fifo_data : holding;
   assign word_sel = ICAP_WORD_W'(source >> {idx_next, 5'd0});

`ifdef ICAP_BITSWAP_EN
   icap_bitswap u_bitswap (
      .word    (word_sel),
      .swapped (word_out)
   );
`else
   assign word_out = word_sel;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         holding      <= '0;
         idx          <= '0;
         data_q       <= '0;
         csib_q       <= CSIB_DISABLE;
         words_sent_q <= '0;
      end else begin
         idx <= idx_next;
         if (bus.abort) begin
            holding <= '0;
         end else if (state == LOAD) begin
            holding <= bus.fifo_data;
         end
         if (state_next == SEND) begin
            csib_q <= CSIB_ENABLE;
            data_q <= word_out;
         end else begin
            csib_q <= CSIB_DISABLE;
         end
         if (csib_q == CSIB_ENABLE) begin
            words_sent_q <= words_sent_q + 32'd1;
         end
      end
   end

   assign bus.fifo_rd_en = rd_en && !reset;
   assign bus.icap_data  = data_q;
   assign bus.icap_csib  = csib_q;
   assign bus.icap_rdwrb = 1'b0;
   assign bus.busy       = (state != IDLE);
   assign bus.words_sent = words_sent_q;

endmodule

// File: tb/tb_icap_word_serializer.sv
// tb/tb_icap_word_serializer.sv - scoreboard bench for icap_word_serializer with a queue-based FIFO and word model
module tb_icap_word_serializer;
   import icap_pkg::*;

   localparam int DS = 64;
   localparam int WC = DS / 32;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   icap_word_serializer_if #(.DATA_SIZE(DS)) bus ();
   icap_word_serializer #(.DATA_SIZE(DS)) dut (.clock(clock), .reset(reset), .bus(bus));

   int          checks = 0;
   int          passed = 0;
   logic [DS-1:0] fifo_q[$];
   logic [31:0] exp_q[$];
   int          exp_sent = 0;
   int          cycle = 0;
   int          first_low, last_low, low_count, rd_count;
   int          rd_cycles[$];
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 8; k++)
            r[8*b + k] = w[8*b + 7 - k];
      return r;
`else
      return w;
`endif
   endfunction

   // monitor: every csib-low cycle must carry the next expected word
   always @(negedge clock) begin
      cycle++;
      if (mon_en) begin
         if (bus.fifo_rd_en) begin
            rd_count++;
            rd_cycles.push_back(cycle);
            if (bus.fifo_empty || bus.abort) check("rd_en_legal", 64'd1, 64'd0);
         end
         if (bus.icap_csib == 1'b0) begin
            if (low_count == 0) first_low = cycle;
            last_low = cycle;
            low_count++;
            exp_sent++;
            check("rdwrb", bus.icap_rdwrb, 64'd0);
            if (exp_q.size() == 0) check("word_expected", 64'd0, 64'd1);
            else check("icap_data", bus.icap_data, exp_q.pop_front());
         end
      end
   end

   task automatic clear_log();
      first_low = 0; last_low = 0; low_count = 0; rd_count = 0;
      rd_cycles.delete();
   endtask

   // one clock: FIFO model pops on rd_en, data presented the cycle after
   task automatic step();
      logic [DS-1:0] popped;
      bit pop;
      popped = '0;
      @(negedge clock); #1;
      pop = bus.fifo_rd_en;
      if (bus.abort || reset) exp_q.delete();
      if (pop && fifo_q.size() != 0) begin
         popped = fifo_q.pop_front();
         for (int i = 0; i < WC; i++) exp_q.push_back(ref_word(popped[32*i +: 32]));
      end
      @(posedge clock); #1;
      if (pop) bus.fifo_data = popped;
      bus.fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic push_word(input logic [DS-1:0] w);
      fifo_q.push_back(w);
      bus.fifo_empty = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         step();
         if (!bus.busy && (fifo_q.size() == 0 || !bus.enable)) return;
      end
      check("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_send();
      for (int n = 0; n < 50; n++) begin
         step();
         if (bus.icap_csib == 1'b0) return;
      end
      check("send_timeout", 64'd1, 64'd0);
   endtask

   logic [31:0] base;
   int          sent_base;

   initial begin
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.abort = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_data = '0;
      repeat (3) step();
      check("reset_csib", bus.icap_csib, 64'd1);
      check("reset_data", bus.icap_data, 64'd0);
      check("reset_busy", bus.busy, 64'd0);
      check("reset_words_sent", bus.words_sent, 64'd0);
      check("reset_rd_en", bus.fifo_rd_en, 64'd0);
      check("reset_rdwrb", bus.icap_rdwrb, 64'd0);
      reset = 1'b0;
      mon_en = 1'b1;
      step();

      // single 64-bit word, low half first
      clear_log();
      bus.enable = 1'b1;
      push_word(64'h11111111_22222222);
      wait_idle();
      check("single_low_cycles", low_count, 64'd2);
      check("single_rd_count", rd_count, 64'd1);
      check("single_latency", (rd_cycles.size() == 1) ? first_low - rd_cycles[0] : -1, 64'd2);
      check("single_words_sent", bus.words_sent, 64'd2);

      // two queued words: overlapped read and a single bubble
      clear_log();
      base = bus.words_sent;
      push_word(64'hA0A1A2A3_B0B1B2B3);
      push_word(64'hC0C1C2C3_D0D1D2D3);
      wait_idle();
      check("b2b_low_cycles", low_count, 64'd4);
      check("b2b_span", last_low - first_low, 64'd4);
      check("b2b_rd_count", rd_count, 64'd2);
      check("b2b_rd_overlap", (rd_cycles.size() == 2) ? rd_cycles[1] : -1, 64'(first_low + 1));
      check("b2b_words_sent", bus.words_sent - base, 64'd4);

      // empty FIFO with enable high
      clear_log();
      repeat (20) step();
      check("empty_rd_count", rd_count, 64'd0);
      check("empty_busy", bus.busy, 64'd0);
      check("empty_csib", bus.icap_csib, 64'd1);

      // enable dropped mid-word still finishes the word
      clear_log();
      push_word(64'h13572468_02468ACE);
      wait_send();
      bus.enable = 1'b0;
      wait_idle();
      check("enable_drop_low_cycles", low_count, 64'd2);
      bus.enable = 1'b1;

      // abort on the first SEND cycle with another word waiting
      clear_log();
      base = bus.words_sent;
      push_word(64'hDEADBEEF_CAFEF00D);
      push_word(64'h01234567_89ABCDEF);
      wait_send();
      bus.abort = 1'b1;
      step();
      check("abort_csib", bus.icap_csib, 64'd1);
      check("abort_busy", bus.busy, 64'd0);
      check("abort_words_sent", bus.words_sent - base, 64'd1);
      repeat (3) step();
      check("abort_rd_count", rd_count, 64'd1);
      bus.abort = 1'b0;
      wait_idle();
      check("abort_resume_words_sent", bus.words_sent - base, 64'd3);

      // bit order of the ICAP word
      push_word(64'h00000000_00000001);
      wait_send();
`ifdef ICAP_BITSWAP_EN
      check("bitswap_word", bus.icap_data, 64'h80);
`else
      check("bitswap_word", bus.icap_data, 64'h1);
`endif
      wait_idle();

      // reset in the middle of a word
      push_word(64'h55555555_66666666);
      wait_send();
      reset = 1'b1;
      step();
      check("reset_mid_csib", bus.icap_csib, 64'd1);
      check("reset_mid_busy", bus.busy, 64'd0);
      check("reset_mid_words_sent", bus.words_sent, 64'd0);
      reset = 1'b0;
      exp_q.delete();
      step();

      // counter wrap
      force dut.words_sent_q = 32'hFFFFFFFF;
      step();
      release dut.words_sent_q;
      push_word(64'h77777777_88888888);
      wait_send();
      step();
      check("wrap_words_sent", bus.words_sent, 64'd0);
      wait_idle();
      check("wrap_words_sent_end", bus.words_sent, 64'd1);

      // randomized traffic with occasional aborts and enable toggles
      base = bus.words_sent;
      sent_base = exp_sent;
      for (int it = 0; it < 60; it++) begin
         int pushes;
         pushes = $urandom_range(0, 2);
         for (int p = 0; p < pushes; p++) push_word({$urandom, $urandom});
         bus.enable = ($urandom_range(0, 3) != 0);
         for (int s = 0; s < int'($urandom_range(1, 8)); s++) begin
            bus.abort = ($urandom_range(0, 24) == 0);
            step();
         end
         bus.abort = 1'b0;
      end
      bus.enable = 1'b1;
      wait_idle();
      step();
      check("random_drained", exp_q.size(), 64'd0);
      check("random_words_sent", bus.words_sent - base, 64'(exp_sent - sent_base));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/icap_word_serializer.md
ICAP_WORD_SERIALIZER -- requirements
Module: icap_word_serializer

Interface
REQ-001 Parameter DATA_SIZE, default 256, FIFO word width in bits; SHALL be a multiple of 32 and >= 32.
REQ-002 Localparam WORD_COUNT, DATA_SIZE/32, number of ICAP words per FIFO word.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high permits new FIFO reads; low finishes the current FIFO word then idles.
REQ-006 abort  input  1  synchronous flush; discards any held or in-flight word.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_rd_en  output  1  active-high FIFO read strobe; data valid one cycle later.
REQ-009 fifo_data  input  DATA_SIZE  FIFO read data.
REQ-010 icap_data  output  32  ICAP write data, registered.
REQ-011 icap_csib  output  1  ICAP chip select, active-low, registered.
REQ-012 icap_rdwrb  output  1  ICAP direction; held 0 (write) at all times.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 words_sent  output  32  count of ICAP words written, wraps 0xFFFFFFFF->0.

Function
REQ-015 States SHALL be IDLE, READ, LOAD, SEND; encoding is a shared-package enum.
REQ-016 IDLE->READ when enable=1 and fifo_empty=0; otherwise stay in IDLE.
REQ-017 READ SHALL assert fifo_rd_en for exactly one cycle, then go to LOAD unconditionally.
REQ-018 LOAD SHALL capture fifo_data into a DATA_SIZE holding register, clear word index to 0, and go to SEND.
REQ-019 SEND SHALL drive icap_csib=0 and icap_data = holding[32*idx+31 : 32*idx] for one cycle per idx, idx 0..WORD_COUNT-1, lowest word first.
REQ-020 On the SEND cycle with idx=WORD_COUNT-1: if enable=1 and fifo_empty=0, assert fifo_rd_en that cycle and go to LOAD (one-cycle csib bubble); otherwise go to IDLE.
REQ-021 icap_csib SHALL be 1 and icap_data SHALL hold its last value in all states other than SEND.
REQ-022 fifo_rd_en SHALL never be asserted while fifo_empty=1, nor while abort=1.
REQ-023 words_sent SHALL increment by 1 on every cycle icap_csib=0.
REQ-024 enable deasserted mid-SEND SHALL NOT truncate the current FIFO word.
REQ-025 abort=1 in any state: next state IDLE, icap_csib=1 the next cycle, holding register and index discarded; data returned by a READ issued before the abort SHALL be dropped; words_sent unchanged.
REQ-026 abort and enable both high: abort wins.
REQ-027 DATA_SIZE=32: WORD_COUNT=1, and each SEND is a single cycle followed by LOAD or IDLE per REQ-020.

Reset
REQ-028 reset SHALL force state IDLE, icap_csib=1, icap_rdwrb=0, fifo_rd_en=0, icap_data=0, busy=0, words_sent=0, and index=0.
REQ-029 reset mid-SEND SHALL discard the remaining words with no further csib-low cycle; reset has priority over abort.

Configuration
REQ-030 Macro ICAP_BITSWAP_EN: when defined, icap_data SHALL be the selected word with the bits reversed within each byte (bit 0<->7 of each byte), as the ICAP primitive requires.
REQ-031 Without ICAP_BITSWAP_EN, the selected word SHALL pass through unmodified; timing and latency are identical in both builds.

Structure
REQ-032 Package icap_pkg SHALL hold the state enum, the ICAP word width constant (32), and the csib enable/disable level constants.
REQ-033 One sub-module, icap_bitswap (32-bit combinational byte-wise bit reversal), SHALL be instantiated only under ICAP_BITSWAP_EN.

Verification
REQ-034 DATA_SIZE=64, fifo word 0x11111111_22222222 -> rd_en pulse, then 2 csib-low cycles with data 0x22222222 then 0x11111111; words_sent=2.
REQ-035 Two FIFO words queued, enable=1 -> second rd_en coincides with the last SEND cycle of word 1, exactly one csib-high bubble, words_sent=4.
REQ-036 abort asserted on the first SEND cycle -> csib=1 the next cycle, state IDLE, words_sent=1, no further rd_en while abort is high.
REQ-037 ICAP_BITSWAP_EN defined, word 0x00000001 -> icap_data=0x00000080; undefined -> 0x00000001.
REQ-038 fifo_empty=1 held for 20 cycles with enable=1 -> fifo_rd_en never asserted, busy=0, csib=1.
REQ-039 words_sent preloaded to 0xFFFFFFFF via force, one word sent -> words_sent=0x00000000.
